// File: rtl/mux3_pkg.sv
// rtl/mux3_pkg.sv - shared types and index helpers for the three-way mux arbiter
package mux3_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'd0;
  localparam sel_t SEL_IN1 = 2'd1;
  localparam sel_t SEL_IN2 = 2'd2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Next requester index in round-robin order (2 wraps to 0).
  function automatic sel_t next_sel(input sel_t s);
    return (s == SEL_IN2) ? SEL_IN0 : sel_t'(s + 2'd1);
  endfunction

  // One-hot vector with bit s set.
  function automatic logic [2:0] sel_onehot(input sel_t s);
    return 3'b001 << s;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational first-pending search over three requests from a start index
module rr_pick3
  import mux3_pkg::*;
(
  input  logic [2:0] req,
  input  sel_t       start,
  output logic       found,
  output sel_t       winner
);

  sel_t s0;
  sel_t s1;
  sel_t s2;

  assign s0 = start;
  assign s1 = next_sel(s0);
  assign s2 = next_sel(s1);

  // Scan start, start+1, start+2 and report the first pending request.
  always_comb begin
    found  = 1'b0;
    winner = s0;
    if (req[s0]) begin
      found  = 1'b1;
      winner = s0;
    end else if (req[s1]) begin
      found  = 1'b1;
      winner = s1;
    end else if (req[s2]) begin
      found  = 1'b1;
      winner = s2;
    end
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// rtl/mux3_rr_arbiter.sv - round-robin arbiter driving the select of a shared 3:1 mux
module mux3_rr_arbiter
  import mux3_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  output logic [2:0]       gnt,
  output logic [1:0]       ctrl,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  arb_state_t state;
  sel_t       last;
  logic [2:0] pick_req;
  sel_t       pick_start;
  logic       found;
  sel_t       winner;
  logic       cur_req;
  logic       at_limit;
  logic       do_grant;
  logic       go_idle;

  assign cur_req  = req[ctrl];
  assign at_limit = (hold_cnt == HOLD_MAX);

  // While granted, search only the other requesters starting after the owner;
  // when idle, search everyone starting after the last winner.
  always_comb begin
    pick_req   = req;
    pick_start = next_sel(last);
    if (state == GRANT) begin
      pick_req   = req & ~sel_onehot(ctrl);
      pick_start = next_sel(ctrl);
    end
  end

  rr_pick3 u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .found  (found),
    .winner (winner)
  );

  // Decide whether this edge hands out a new grant or falls back to idle.
  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    if (state == IDLE) begin
      do_grant = found;
    end else begin
      do_grant = found && (!cur_req || at_limit);
      go_idle  = !cur_req && !found;
    end
  end

  // Arbitration state, registered grant/select outputs and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      ctrl     <= SEL_IN0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      last     <= SEL_IN2;
    end else if (do_grant) begin
      state    <= GRANT;
      gnt      <= sel_onehot(winner);
      ctrl     <= winner;
      valid    <= 1'b1;
      hold_cnt <= '0;
      last     <= winner;
    end else if (go_idle) begin
      // ctrl is left alone so the mux output stays put while idle.
      state    <= IDLE;
      gnt      <= 3'b000;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else if (state == GRANT && !at_limit) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb/tb_mux3_rr_arbiter.sv - directed self-checking bench for mux3_rr_arbiter
module tb_mux3_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;

  logic [2:0] gnt8;
  logic [1:0] ctrl8;
  logic       valid8;
  logic [2:0] hold8;

  logic [2:0] gnt1;
  logic [1:0] ctrl1;
  logic       valid1;
  logic [0:0] hold1;

  int n_checks;
  int n_fail;

  mux3_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt8),
    .ctrl     (ctrl8),
    .valid    (valid8),
    .hold_cnt (hold8)
  );

  mux3_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt1),
    .ctrl     (ctrl1),
    .valid    (valid1),
    .hold_cnt (hold1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later and check structural invariants on both instances.
  task automatic step();
    @(posedge clk);
    #1;
    n_checks++;
    if (!$onehot0(gnt8) || valid8 !== (|gnt8) || ctrl8 === 2'd3) begin
      n_fail++;
      $display("FAIL invariant_dut8: gnt=%b valid=%b ctrl=%0d, required onehot0 gnt, valid=|gnt, ctrl!=3",
               gnt8, valid8, ctrl8);
    end
    n_checks++;
    if (!$onehot0(gnt1) || valid1 !== (|gnt1) || ctrl1 === 2'd3) begin
      n_fail++;
      $display("FAIL invariant_dut1: gnt=%b valid=%b ctrl=%0d, required onehot0 gnt, valid=|gnt, ctrl!=3",
               gnt1, valid1, ctrl1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt8 !== 3'b000 || ctrl8 !== 2'd0 || valid8 !== 1'b0 || hold8 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: gnt=%b ctrl=%0d valid=%b hold=%0d, required 000/0/0/0",
               gnt8, ctrl8, valid8, hold8);
    end
    req = 3'b111;
    step();
    req = 3'b000;
    n_checks++;
    if (gnt8 !== 3'b001 || ctrl8 !== 2'd0 || valid8 !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%b ctrl=%0d valid=%b, required 001/0/1", gnt8, ctrl8, valid8);
    end
    step();
    n_checks++;
    if (gnt8 !== 3'b000 || valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_release: gnt=%b valid=%b, required 000/0", gnt8, valid8);
    end
  endtask

  task automatic test_single();
    logic [2:0] exp_hold;
    do_reset();
    req = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_hold = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
      n_checks++;
      if (gnt8 !== 3'b010 || ctrl8 !== 2'd1 || hold8 !== exp_hold) begin
        n_fail++;
        $display("FAIL single_hold cycle %0d: gnt=%b ctrl=%0d hold=%0d, required 010/1/%0d",
                 k, gnt8, ctrl8, hold8, exp_hold);
      end
    end
    req = 3'b000;
    step();
    n_checks++;
    if (gnt8 !== 3'b000 || valid8 !== 1'b0 || ctrl8 !== 2'd1) begin
      n_fail++;
      $display("FAIL single_drop: gnt=%b valid=%b ctrl=%0d, required 000/0/1", gnt8, valid8, ctrl8);
    end
  endtask

  // After requester 1 was last served, {0,1} pending from idle must go to 0 (search starts at 2).
  task automatic test_rr_pointer();
    req = 3'b011;
    step();
    n_checks++;
    if (gnt8 !== 3'b001 || ctrl8 !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_pointer: gnt=%b ctrl=%0d, required 001/0", gnt8, ctrl8);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_idx;
    logic [2:0] exp_gnt;
    logic [2:0] exp_hold;
    do_reset();
    req = 3'b111;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_idx  = 2'(((k - 1) / 8) % 3);
      exp_gnt  = 3'b001 << exp_idx;
      exp_hold = 3'((k - 1) % 8);
      n_checks++;
      if (gnt8 !== exp_gnt || ctrl8 !== exp_idx || hold8 !== exp_hold) begin
        n_fail++;
        $display("FAIL contention cycle %0d: gnt=%b ctrl=%0d hold=%0d, required %b/%0d/%0d",
                 k, gnt8, ctrl8, hold8, exp_gnt, exp_idx, exp_hold);
      end
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 3'b101;
    step();
    n_checks++;
    if (gnt8 !== 3'b001 || ctrl8 !== 2'd0) begin
      n_fail++;
      $display("FAIL handoff_first: gnt=%b ctrl=%0d, required 001/0", gnt8, ctrl8);
    end
    req = 3'b100;
    step();
    n_checks++;
    if (gnt8 !== 3'b100 || ctrl8 !== 2'd2 || valid8 !== 1'b1 || hold8 !== 3'd0) begin
      n_fail++;
      $display("FAIL handoff_next: gnt=%b ctrl=%0d valid=%b hold=%0d, required 100/2/1/0",
               gnt8, ctrl8, valid8, hold8);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 3'b100;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (gnt8 !== 3'b100 || ctrl8 !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_setup: gnt=%b ctrl=%0d, required 100/2", gnt8, ctrl8);
    end
    req   = 3'b111;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (gnt8 !== 3'b000 || ctrl8 !== 2'd0 || valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: gnt=%b ctrl=%0d valid=%b, required 000/0/0", gnt8, ctrl8, valid8);
    end
    step();
    n_checks++;
    if (gnt8 !== 3'b001 || ctrl8 !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_after: gnt=%b ctrl=%0d, required 001/0", gnt8, ctrl8);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_max_hold1();
    logic [2:0] exp_gnt;
    do_reset();
    req = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_gnt = (k % 2 == 1) ? 3'b001 : 3'b010;
      n_checks++;
      if (gnt1 !== exp_gnt || hold1 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold1_rotate cycle %0d: gnt=%b hold=%0d, required %b/0", k, gnt1, hold1, exp_gnt);
      end
    end
    req = 3'b000;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 3'b000;
    test_reset();
    test_single();
    test_rr_pointer();
    test_contention();
    test_back_to_back();
    test_reset_mid_grant();
    test_max_hold1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
